// File: rtl/bias_stream_ctrl.sv
// Bias ROM sequencer: streams NUM_KERN words NUM_PASS times into an ap_fifo port via a 2-entry skid.
// Optional stall counter output enabled by defining BIAS_STALL_CNT_EN.
module bias_stream_ctrl #(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned NUM_KERN    = 32,
  parameter int unsigned NUM_PASS    = 1,
  parameter int unsigned ADDR_W      = (NUM_KERN > 1) ? $clog2(NUM_KERN) : 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic [ADDR_W-1:0]      rom_address,
  output logic                   rom_ce,
  input  logic [COEFF_WIDTH-1:0] rom_q,
  output logic [COEFF_WIDTH-1:0] output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write
`ifdef BIAS_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned PassW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_KERN - 1);
  localparam logic [PassW-1:0]  LastPass = PassW'(NUM_PASS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [PassW-1:0]        pass_q;
  logic                    inflight_q;
  logic [1:0]              cnt_q;
  logic [COEFF_WIDTH-1:0]  head_q;
  logic [COEFF_WIDTH-1:0]  tail_q;

  logic       pop;
  logic [1:0] occ_after_pop;
  logic       issue;
  logic       drained;

  // Occupancy is judged after this cycle's pop so a steady stream sustains one read per cycle.
  always_comb begin
    pop           = (cnt_q != 2'd0) && output_V_full_n;
    occ_after_pop = cnt_q - {1'b0, pop};
    issue         = (state_q == StRun) && ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
    drained       = (occ_after_pop == 2'd0) && !inflight_q;
  end

  assign ap_idle        = (state_q == StIdle);
  assign ap_done        = (state_q == StDone);
  assign rom_ce         = issue;
  assign rom_address    = addr_q;
  assign output_V_write = (cnt_q != 2'd0);
  assign output_V_din   = head_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle:  if (ap_start) state_q <= StRun;
        StRun:   if (issue && (addr_q == LastAddr) && (pass_q == LastPass)) state_q <= StDrain;
        StDrain: if (drained) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (issue) begin
        if (addr_q == LastAddr) begin
          addr_q <= '0;
          pass_q <= (pass_q == LastPass) ? '0 : pass_q + PassW'(1);
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end

      inflight_q <= issue;
      cnt_q      <= occ_after_pop + {1'b0, inflight_q};

      // Later assignments win: a capture lands in whichever slot is free after the pop.
      if (pop) head_q <= tail_q;
      if (inflight_q) begin
        if (occ_after_pop == 2'd0) head_q <= rom_q;
        else                       tail_q <= rom_q;
      end
    end
  end

`ifdef BIAS_STALL_CNT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if ((state_q == StIdle) && ap_start) begin
      stall_cnt <= '0;
    end else if (output_V_write && !output_V_full_n && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bias_stream_ctrl.sv
// Directed bench for bias_stream_ctrl: three instances (K4/P1, K4/P3, K1/P2) with ROM models q=addr+0x100.
module tb_bias_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Instance A: NUM_KERN=4, NUM_PASS=1
  logic start_a = 1'b0, full_a = 1'b1;
  logic idle_a, done_a, ce_a, wr_a;
  logic [1:0] addr_a;
  logic [15:0] q_a = '0, din_a;
  // Instance B: NUM_KERN=4, NUM_PASS=3
  logic start_b = 1'b0, full_b = 1'b1;
  logic idle_b, done_b, ce_b, wr_b;
  logic [1:0] addr_b;
  logic [15:0] q_b = '0, din_b;
  // Instance C: NUM_KERN=1, NUM_PASS=2
  logic start_c = 1'b0, full_c = 1'b1;
  logic idle_c, done_c, ce_c, wr_c;
  logic [0:0] addr_c;
  logic [15:0] q_c = '0, din_c;
`ifdef BIAS_STALL_CNT_EN
  logic [31:0] stall_a, stall_b, stall_c;
`endif

  bias_stream_ctrl #(.COEFF_WIDTH(16), .NUM_KERN(4), .NUM_PASS(1)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_a), .ap_idle(idle_a), .ap_done(done_a),
    .rom_address(addr_a), .rom_ce(ce_a), .rom_q(q_a), .output_V_din(din_a),
    .output_V_full_n(full_a), .output_V_write(wr_a)
`ifdef BIAS_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  bias_stream_ctrl #(.COEFF_WIDTH(16), .NUM_KERN(4), .NUM_PASS(3)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_b), .ap_idle(idle_b), .ap_done(done_b),
    .rom_address(addr_b), .rom_ce(ce_b), .rom_q(q_b), .output_V_din(din_b),
    .output_V_full_n(full_b), .output_V_write(wr_b)
`ifdef BIAS_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  bias_stream_ctrl #(.COEFF_WIDTH(16), .NUM_KERN(1), .NUM_PASS(2)) u_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_c), .ap_idle(idle_c), .ap_done(done_c),
    .rom_address(addr_c), .rom_ce(ce_c), .rom_q(q_c), .output_V_din(din_c),
    .output_V_full_n(full_c), .output_V_write(wr_c)
`ifdef BIAS_STALL_CNT_EN
    , .stall_cnt(stall_c)
`endif
  );

  // ROM models with one-cycle read latency
  always @(posedge clk) begin
    if (ce_a) q_a <= 16'h100 + 16'(addr_a);
    if (ce_b) q_b <= 16'h100 + 16'(addr_b);
    if (ce_c) q_c <= 16'h100 + 16'(addr_c);
  end

  // Transfer capture and hold-while-stalled checks
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  logic        stl_a = 1'b0, stl_b = 1'b0;
  logic [15:0] sdin_a = '0, sdin_b = '0;
  always @(negedge clk) begin
    if (stl_a) begin
      check("a_hold_write", 32'(wr_a), 32'd1);
      check("a_hold_din", 32'(din_a), 32'(sdin_a));
    end
    if (stl_b) begin
      check("b_hold_write", 32'(wr_b), 32'd1);
      check("b_hold_din", 32'(din_b), 32'(sdin_b));
    end
    stl_a  = wr_a && !full_a && rst_n;
    stl_b  = wr_b && !full_b && rst_n;
    sdin_a = din_a;
    sdin_b = din_b;
    if (wr_a && full_a) got_a.push_back(din_a);
    if (wr_b && full_b) got_b.push_back(din_b);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int a_wr[1:8]   = '{0, 0, 1, 1, 1, 1, 0, 0};
  int a_done[1:8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int a_idle[1:8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  int c_wr[1:7]   = '{0, 0, 1, 1, 0, 0, 0};
  int c_done[1:7] = '{0, 0, 0, 0, 1, 0, 0};
  int c_idle[1:7] = '{0, 0, 0, 0, 0, 1, 0};
  int c_ce[1:7]   = '{1, 1, 0, 0, 0, 0, 1};

  initial begin
    int n;
    // Reset values while held
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", 32'(idle_a), 32'd1);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ce", 32'(ce_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_write", 32'(wr_a), 32'd0);
    check("rst_din", 32'(din_a), 32'd0);
    rst_n = 1'b1;

    // No start: stays idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("noStart_idle_wr_ce", 32'({idle_a, wr_a, ce_a}), 32'b100);
    end

    // A: single pass, full_n high
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check("a_first_ce", 32'(ce_a), 32'd1);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      check($sformatf("a_write_t%0d", t), 32'(wr_a), 32'(a_wr[t]));
      check($sformatf("a_done_t%0d", t), 32'(done_a), 32'(a_done[t]));
      check($sformatf("a_idle_t%0d", t), 32'(idle_a), 32'(a_idle[t]));
      if (a_wr[t] == 1) check($sformatf("a_din_t%0d", t), 32'(din_a), 32'h100 + 32'(t - 3));
    end

    // B: three passes with random back-pressure
    got_b.delete();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (!done_b && n < 400) begin
      full_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!done_b) begin @(posedge clk); #1; end
      n++;
    end
    check("b_done_seen", 32'(done_b), 32'd1);
    full_b = 1'b1;
    check("b_word_count", 32'(got_b.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      if (i < got_b.size()) check($sformatf("b_word%0d", i), 32'(got_b[i]), 32'h100 + 32'(i % 4));

    // A: ten stall cycles after the first write
    got_a.delete();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    @(negedge clk);
    while (!wr_a && n < 10) begin @(negedge clk); n++; end
    check("stall_first_write", 32'(wr_a), 32'd1);
    @(posedge clk); #1 full_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_ce_off%0d", i), 32'(ce_a), 32'd0);
      check($sformatf("stall_din%0d", i), 32'(din_a), 32'h101);
    end
    @(posedge clk); #1 full_a = 1'b1;
    n = 0;
    while (!done_a && n < 30) begin @(negedge clk); n++; end
    check("stall_done_seen", 32'(done_a), 32'd1);
`ifdef BIAS_STALL_CNT_EN
    check("stall_cnt_at_done", stall_a, 32'd10);
`endif
    check("stall_word_count", 32'(got_a.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_a.size()) check($sformatf("stall_word%0d", i), 32'(got_a[i]), 32'h100 + 32'(i));

    // A: asynchronous reset after two writes, then restart
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (wr_a) n++;
    end
    check("arst_two_writes", 32'(n), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_idle", 32'(idle_a), 32'd1);
    check("arst_write", 32'(wr_a), 32'd0);
    check("arst_ce", 32'(ce_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    check("arst_addr", 32'(addr_a), 32'd0);
    check("arst_din", 32'(din_a), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    got_a.delete();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while (!done_a && n < 30) begin @(negedge clk); n++; end
    check("restart_done_seen", 32'(done_a), 32'd1);
    check("restart_count", 32'(got_a.size()), 32'd4);
    if (got_a.size() > 0) check("restart_first", 32'(got_a[0]), 32'h100);
    if (got_a.size() > 3) check("restart_last", 32'(got_a[3]), 32'h103);

    // C: NUM_KERN=1, NUM_PASS=2, start held high
    @(posedge clk); #1 start_c = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      check($sformatf("c_write_t%0d", t), 32'(wr_c), 32'(c_wr[t]));
      check($sformatf("c_done_t%0d", t), 32'(done_c), 32'(c_done[t]));
      check($sformatf("c_idle_t%0d", t), 32'(idle_c), 32'(c_idle[t]));
      check($sformatf("c_ce_t%0d", t), 32'(ce_c), 32'(c_ce[t]));
      check($sformatf("c_addr_t%0d", t), 32'(addr_c), 32'd0);
      if (c_wr[t] == 1) check($sformatf("c_din_t%0d", t), 32'(din_c), 32'h100);
    end
    start_c = 1'b0;
    n = 0;
    while (!done_c && n < 20) begin @(negedge clk); n++; end
    check("c_second_done", 32'(done_c), 32'd1);
    @(negedge clk);
    check("c_idle_after", 32'(idle_c), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
